// File: rtl/apb_gpio_irq_if.sv
// APB3 bus bundle for the GPIO controller.
// The master drives the request side; the slave returns read data, ready and error.
interface apb_gpio_irq_if #(
  parameter int NPINS      = 8,
  parameter int ADDR_WIDTH = 4
);
  logic                  pselx;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [NPINS-1:0]      pwdata;
  logic [NPINS-1:0]      prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    output pselx, penable, pwrite, paddr, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  pselx, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_gpio_irq.sv
// APB3 GPIO controller with programmable wait states, input synchroniser,
// per-pin edge/level interrupts (W1C status) and atomic set/clear of OUT.
module apb_gpio_irq #(
  parameter int NPINS       = 8,
  parameter int ADDR_WIDTH  = 4,
  parameter int PREADY_DEL  = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic             pclk,
  input  logic             preset,
  apb_gpio_irq_if.slave    bus,
  input  logic [NPINS-1:0] y,
  output logic [NPINS-1:0] oe,
  output logic [NPINS-1:0] pu,
  output logic [NPINS-1:0] pd,
  output logic [NPINS-1:0] a,
  output logic             irq
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  localparam logic [31:0] IDX_OE       = 32'd0;
  localparam logic [31:0] IDX_PU       = 32'd1;
  localparam logic [31:0] IDX_PD       = 32'd2;
  localparam logic [31:0] IDX_OUT      = 32'd3;
  localparam logic [31:0] IDX_IN       = 32'd4;
  localparam logic [31:0] IDX_EN       = 32'd5;
  localparam logic [31:0] IDX_TYPE     = 32'd6;
  localparam logic [31:0] IDX_POL      = 32'd7;
  localparam logic [31:0] IDX_STATUS   = 32'd8;
  localparam logic [31:0] IDX_OUT_SET  = 32'd9;
  localparam logic [31:0] IDX_OUT_CLR  = 32'd10;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q;
  logic [31:0]      idx;
  logic             ready, mapped, err, wr_commit;

  logic [NPINS-1:0] oe_q, pu_q, pd_q, out_q;
  logic [NPINS-1:0] en_q, type_q, pol_q, status_q, status_d;
  logic [NPINS-1:0] sync_ff [SYNC_STAGES];
  logic [NPINS-1:0] sync_q, prev_q, evt, rd_data;

  // Zero-extend the index so indices beyond the map decode as unmapped at any width.
  assign idx       = 32'(bus.paddr);
  assign mapped    = (idx <= IDX_OUT_CLR);
  assign ready     = (state_q == ACCESS) && (cnt_q == 3'(PREADY_DEL));
  assign err       = ready && (!mapped || (bus.pwrite && idx == IDX_IN));
  assign wr_commit = bus.pselx && bus.penable && ready && bus.pwrite && !err;

  // NOTE: every signal assigned in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.pselx && !bus.penable) state_d = SETUP;
      SETUP:   state_d = bus.pselx ? ACCESS : IDLE;
      ACCESS: begin
        if (!bus.pselx)  state_d = IDLE;
        else if (ready)  state_d = bus.penable ? IDLE : SETUP;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == SETUP)              cnt_q <= '0;
      else if (state_q == ACCESS && !ready) cnt_q <= cnt_q + 3'd1;
    end
  end

  // Pad input synchroniser plus the previous-sample register for edge detect.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_ff[i] <= '0;
      prev_q <= '0;
    end else begin
      sync_ff[0] <= y;
      for (int i = 1; i < SYNC_STAGES; i++) sync_ff[i] <= sync_ff[i-1];
      prev_q <= sync_q;
    end
  end

  assign sync_q = sync_ff[SYNC_STAGES-1];

  // Edge mode follows POL for rising/falling; level mode fires while sync == POL.
  assign evt = (type_q & ((pol_q & sync_q & ~prev_q) | (~pol_q & ~sync_q & prev_q)))
             | (~type_q & ~(sync_q ^ pol_q));

  // A W1C clear and a new event on the same bit resolve to set.
  always_comb begin
    status_d = status_q;
    if (wr_commit && idx == IDX_STATUS) status_d = status_d & ~bus.pwdata;
    status_d = status_d | (evt & en_q);
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      oe_q     <= '0;
      pu_q     <= '0;
      pd_q     <= '0;
      out_q    <= '0;
      en_q     <= '0;
      type_q   <= '0;
      pol_q    <= '0;
      status_q <= '0;
      irq      <= 1'b0;
    end else begin
      status_q <= status_d;
      irq      <= |(status_q & en_q);
      if (wr_commit) begin
        case (idx)
          IDX_OE:      oe_q   <= bus.pwdata;
          IDX_PU:      pu_q   <= bus.pwdata;
          IDX_PD:      pd_q   <= bus.pwdata;
          IDX_OUT:     out_q  <= bus.pwdata;
          IDX_EN:      en_q   <= bus.pwdata;
          IDX_TYPE:    type_q <= bus.pwdata;
          IDX_POL:     pol_q  <= bus.pwdata;
          IDX_OUT_SET: out_q  <= out_q | bus.pwdata;
          IDX_OUT_CLR: out_q  <= out_q & ~bus.pwdata;
          default:     ;
        endcase
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (idx)
      IDX_OE:     rd_data = oe_q;
      IDX_PU:     rd_data = pu_q;
      IDX_PD:     rd_data = pd_q;
      IDX_OUT:    rd_data = out_q;
      IDX_IN:     rd_data = sync_q;
      IDX_EN:     rd_data = en_q;
      IDX_TYPE:   rd_data = type_q;
      IDX_POL:    rd_data = pol_q;
      IDX_STATUS: rd_data = status_q;
      default:    rd_data = '0;
    endcase
  end

  assign bus.pready  = ready;
  assign bus.pslverr = err;
  assign bus.prdata  = (ready && !bus.pwrite) ? rd_data : '0;

  assign oe = oe_q;
  assign pu = pu_q;
  assign pd = pd_q & ~pu_q;
  assign a  = out_q;

endmodule

// File: tb/tb_apb_gpio_irq.sv
// Directed bench: dut0 runs zero wait states, dut1 runs PREADY_DEL = 3.
// Both share the clock, reset, pads and request signals; pselx picks the target.
module tb_apb_gpio_irq;

  localparam int NP = 8;
  localparam int AW = 4;

  logic          pclk = 1'b0;
  logic          preset;
  logic          psel0, psel1, penable, pwrite;
  logic [AW-1:0] paddr;
  logic [NP-1:0] pwdata, y;
  logic [NP-1:0] oe0, pu0, pd0, a0, oe1, pu1, pd1, a1;
  logic          irq0, irq1;
  logic [NP-1:0] a_before;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  apb_gpio_irq_if #(.NPINS(NP), .ADDR_WIDTH(AW)) bus0 ();
  apb_gpio_irq_if #(.NPINS(NP), .ADDR_WIDTH(AW)) bus1 ();

  assign bus0.pselx   = psel0;
  assign bus0.penable = penable;
  assign bus0.pwrite  = pwrite;
  assign bus0.paddr   = paddr;
  assign bus0.pwdata  = pwdata;
  assign bus1.pselx   = psel1;
  assign bus1.penable = penable;
  assign bus1.pwrite  = pwrite;
  assign bus1.paddr   = paddr;
  assign bus1.pwdata  = pwdata;

  apb_gpio_irq #(.NPINS(NP), .ADDR_WIDTH(AW), .PREADY_DEL(0), .SYNC_STAGES(2)) dut0 (
    .pclk(pclk), .preset(preset), .bus(bus0), .y(y),
    .oe(oe0), .pu(pu0), .pd(pd0), .a(a0), .irq(irq0)
  );

  apb_gpio_irq #(.NPINS(NP), .ADDR_WIDTH(AW), .PREADY_DEL(3), .SYNC_STAGES(2)) dut1 (
    .pclk(pclk), .preset(preset), .bus(bus1), .y(y),
    .oe(oe1), .pu(pu1), .pd(pd1), .a(a1), .irq(irq1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transfer; returns read data, error flag and the number of
  // enable-phase cycles that had pready low.
  task automatic xfer(input bit which, input bit wr, input logic [AW-1:0] addr,
                      input logic [NP-1:0] wdata, output logic [NP-1:0] rdata,
                      output logic err, output int waits);
    psel0   = !which;
    psel1   = which;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = wdata;
    @(posedge pclk); #1;
    penable = 1'b1;
    waits   = 0;
    while (!(which ? bus1.pready : bus0.pready) && waits < 40) begin
      @(posedge pclk); #1;
      waits++;
    end
    check("pready_seen", which ? bus1.pready : bus0.pready, 1);
    rdata    = which ? bus1.prdata : bus0.prdata;
    err      = which ? bus1.pslverr : bus0.pslverr;
    a_before = a1;
    @(posedge pclk); #1;
    psel0   = 1'b0;
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr(input bit which, input logic [AW-1:0] addr, input logic [NP-1:0] d);
    logic [NP-1:0] r;
    logic          e;
    int            w;
    xfer(which, 1'b1, addr, d, r, e, w);
    check("wr_pslverr", e, 0);
  endtask

  task automatic rd_chk(input string tag, input bit which, input logic [AW-1:0] addr,
                        input logic [NP-1:0] exp);
    logic [NP-1:0] r;
    logic          e;
    int            w;
    xfer(which, 1'b0, addr, '0, r, e, w);
    check(tag, r, exp);
    check({tag, "_pslverr"}, e, 0);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  logic [NP-1:0] r;
  logic          e;
  int            w;

  initial begin
    preset = 1'b1;
    {psel0, psel1, penable, pwrite} = '0;
    paddr  = '0;
    pwdata = '0;
    y      = '0;
    cycles(2);
    check("rst_pready", bus1.pready, 0);
    check("rst_oe_a_irq", {oe1, a1, irq1}, 0);
    preset = 1'b0;
    cycles(1);

    // Reads after reset; one SETUP-state cycle precedes the first ACCESS cycle.
    for (int i = 0; i <= 10; i++) begin
      xfer(1'b0, 1'b0, AW'(i), '0, r, e, w);
      check($sformatf("rst_read_%0d", i), r, 0);
      check($sformatf("rst_err_%0d", i), e, 0);
      check($sformatf("rst_waits_%0d", i), w, 1);
    end
    xfer(1'b0, 1'b0, 4'd12, '0, r, e, w);
    check("unmapped_rdata", r, 0);
    check("unmapped_pslverr", e, 1);

    // Wait states: SETUP-state cycle plus three low ACCESS cycles before pready.
    xfer(1'b1, 1'b1, 4'd3, 8'hA5, r, e, w);
    check("out_waits", w, 4);
    check("a_before_commit", a_before, 8'h00);
    check("a_after_commit", a1, 8'hA5);
    wr(1'b1, 4'd9, 8'h0F);
    check("out_set", a1, 8'hAF);
    wr(1'b1, 4'd10, 8'hA0);
    check("out_clr", a1, 8'h0F);
    rd_chk("out_set_reads0", 1'b1, 4'd9, 8'h00);

    // Pull-up overrides pull-down on shared pins.
    wr(1'b1, 4'd1, 8'h03);
    wr(1'b1, 4'd2, 8'h06);
    check("pu", pu1, 8'h03);
    check("pd_masked", pd1, 8'h04);
    rd_chk("pd_read", 1'b1, 4'd2, 8'h06);

    // Rising-edge interrupt on pin 0: STATUS at edge 3, irq at edge 4.
    wr(1'b1, 4'd6, 8'h01);
    wr(1'b1, 4'd7, 8'h01);
    wr(1'b1, 4'd5, 8'h01);
    check("irq_idle", irq1, 0);
    y = 8'h01;
    cycles(3);
    check("irq_edge3", irq1, 0);
    cycles(1);
    check("irq_edge4", irq1, 1);
    rd_chk("status_edge", 1'b1, 4'd8, 8'h01);
    wr(1'b1, 4'd8, 8'h01);
    cycles(1);
    check("irq_after_w1c", irq1, 0);
    y = 8'h00;
    cycles(6);
    check("irq_falling", irq1, 0);
    rd_chk("status_falling", 1'b1, 4'd8, 8'h00);

    // Level-low interrupt on pin 1 with y[1] held low.
    wr(1'b1, 4'd5, 8'h00);
    wr(1'b1, 4'd6, 8'h00);
    wr(1'b1, 4'd7, 8'h00);
    wr(1'b1, 4'd8, 8'hFF);
    wr(1'b1, 4'd5, 8'h02);
    cycles(3);
    check("irq_level", irq1, 1);
    wr(1'b1, 4'd8, 8'h02);
    cycles(1);
    check("irq_level_w1c_1", irq1, 1);
    cycles(1);
    check("irq_level_w1c_2", irq1, 1);
    rd_chk("status_level", 1'b1, 4'd8, 8'h02);
    wr(1'b1, 4'd5, 8'h00);
    cycles(1);
    check("irq_masked", irq1, 0);
    rd_chk("status_kept", 1'b1, 4'd8, 8'h02);

    // Write to the read-only IN register.
    y = 8'h5A;
    cycles(4);
    xfer(1'b1, 1'b1, 4'd4, 8'hFF, r, e, w);
    check("in_write_pslverr", e, 1);
    rd_chk("in_unchanged", 1'b1, 4'd4, 8'h5A);

    // Reset asserted during a wait state of an OE write.
    psel1   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 4'd0;
    pwdata  = 8'hFF;
    cycles(1);
    penable = 1'b1;
    cycles(1);
    check("mid_wait_pready", bus1.pready, 0);
    preset = 1'b1;
    #1;
    check("reset_pready", bus1.pready, 0);
    check("reset_pu", pu1, 8'h00);
    cycles(1);
    psel1   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    preset  = 1'b0;
    cycles(1);
    check("reset_oe_pad", oe1, 8'h00);
    rd_chk("reset_oe_reg", 1'b1, 4'd0, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_gpio_irq.md
Name: apb_gpio_irq

Overview:
- Parametrised APB3 GPIO controller, successor to the 8-bit GPIO register block in GPIO_Expander.
- Sits between the APB bus and the pad ring.
- Adds over the 8-bit block:
  - NPINS-wide registers.
  - Programmable wait states with a registered wait counter.
  - A synchroniser on pad inputs.
  - Per-pin edge/level interrupts with write-1-to-clear status.
  - Atomic set/clear of the output register, and PSLVERR.

Parameters:
NPINS, 8, pin count and data width (1..32)
ADDR_WIDTH, 4, register index width (paddr is a register index, not a byte address)
PREADY_DEL, 0, APB wait states inserted per access (0..7)
SYNC_STAGES, 2, flops in the input synchroniser (2..4)

Ports:
pclk  input  1  clock, all logic on rising edge
preset  input  1  reset; asynchronous, active-high
pselx  input  1  APB select
penable  input  1  APB enable
pwrite  input  1  1 = write, 0 = read
paddr  input  ADDR_WIDTH  register index
pwdata  input  NPINS  write data
prdata  output  NPINS  read data
pready  output  1  transfer complete
pslverr  output  1  transfer error, valid only with pready
y  input  NPINS  pad input values (asynchronous)
oe  output  NPINS  pad output enable
pu  output  NPINS  pull-up enable
pd  output  NPINS  pull-down enable; forced 0 on any pin whose pu bit is 1
a  output  NPINS  pad output value
irq  output  1  interrupt, registered

Behaviour:
- Register map (index: name, access):
  - 0 OE rw
  - 1 PU rw
  - 2 PD rw
  - 3 OUT rw (drives a)
  - 4 IN ro (synchronised y)
  - 5 IRQ_EN rw
  - 6 IRQ_TYPE rw (0 = level, 1 = edge)
  - 7 IRQ_POL rw (0 = low/falling, 1 = high/rising)
  - 8 IRQ_STATUS rw1c
  - 9 OUT_SET wo (OUT |= pwdata), reads 0
  - 10 OUT_CLR wo (OUT &= ~pwdata), reads 0
- Reset (preset = 1, asynchronous):
  - All registers, synchroniser flops, prev-sample register, wait counter and irq go to 0.
  - FSM goes to IDLE; pready, pslverr and prdata are 0.
  - A transfer in progress is aborted and no write is committed.
- Access FSM:
  - IDLE -> SETUP on pselx & !penable; the wait counter cnt is cleared in SETUP.
  - SETUP -> ACCESS on the next cycle (pselx & penable).
  - ACCESS: pready = (cnt == PREADY_DEL), combinational from the state and cnt. cnt increments each ACCESS cycle while pready = 0.
  - pready is therefore high in access cycle PREADY_DEL+1 (PREADY_DEL = 0 gives a zero-wait transfer).
  - ACCESS -> SETUP on completion if pselx & !penable (back-to-back transfer); ACCESS -> IDLE if pselx = 0.
  - pselx dropping mid-ACCESS returns the FSM to IDLE with no commit.
- Writes commit on the rising edge where pselx & penable & pready & pwrite. Exactly one commit per transfer.
- Reads:
  - prdata is the selected register while pready & !pwrite; otherwise 0.
  - Write-only and unmapped indices read 0.
- pslverr = pready & (unmapped index, or write to IN).
  - An erroring write changes no state.
  - A read of an unmapped index returns 0 with pslverr = 1.
- Input path: y passes through SYNC_STAGES flops to give sync. prev <= sync every cycle.
- Event per pin:
  - Edge mode: sync & !prev when POL = 1; !sync & prev when POL = 0.
  - Level mode: sync == POL.
- Status set rule: STATUS[i] <= 1 on an event when IRQ_EN[i] = 1. Events on disabled pins are dropped.
- W1C: a write of 1 clears the STATUS bit; writing 0 has no effect.
- Same-cycle set and clear on one bit: the set wins. A held level event therefore re-asserts the bit on the next cycle.
- irq <= |(STATUS & IRQ_EN), registered, so it updates one cycle after STATUS. Clearing IRQ_EN masks irq without clearing STATUS.
- Latency from a y change to a STATUS bit is SYNC_STAGES+1 cycles (edge mode). irq follows one cycle later.
- Widths:
  - Writes use pwdata[NPINS-1:0].
  - Indices above 10 are unmapped, including indices not reachable when ADDR_WIDTH is smaller.

Test Plan:
1. Reset then read all 11 indices with PREADY_DEL = 0 -> every read returns 0, pready high in the first ACCESS cycle, pslverr = 0; index 12 read -> prdata = 0, pslverr = 1.
2. PREADY_DEL = 3: write OUT = 0xA5 -> pready low for 3 ACCESS cycles, high in the 4th; a = 0xA5 only after the completing edge. Then OUT_SET 0x0F -> a = 0xAF; OUT_CLR 0xA0 -> a = 0x0F.
3. Write PU = 0x03, PD = 0x06 -> pu = 0x03, pd = 0x04; read PD returns 0x06.
4. IRQ_EN = 0x01, TYPE = 0x01, POL = 0x01; y[0] 0 -> 1 -> STATUS = 0x01 after 3 cycles, irq = 1 the cycle after. Write STATUS = 0x01 -> irq = 0. Falling y[0] -> no event.
5. Level mode, POL = 0, y[1] held low, EN = 0x02: W1C of bit 1 -> bit 1 re-sets the next cycle and irq stays 1. Clear EN -> irq = 0 with STATUS still 0x02.
6. Write IN = 0xFF -> pslverr = 1 and IN is unchanged. Assert preset during a wait-state write -> pready = 0 and the target register stays 0.
